// File: rtl/motor_cmd_ctrl.sv
// Command scheduler between the SPI slave and the per-motor pwm period registers.
// Latency: spi_ready rise to busy is 3 clk; busy lasts NUM_MOTORS+2 clk (2 clk for an empty mask).
// Backpressure: one pending word is buffered while busy; a further word is dropped and flagged as overrun.
//
// Ports:
//   clk, reset        system clock, synchronous active-high reset
//   spi_word          received SPI word, stable while spi_ready is high
//   spi_ready         SPI data_ready, asynchronous to clk (synchronized here)
//   period_out        motor i period at [i*PERIOD_W +: PERIOD_W]
//   reply_word        status word for the next SPI transfer
//   busy              high while a command is being decoded/applied/replied
//   failsafe          high while the watchdog holds every output at 0
//
// Optional build macro MOTOR_CTRL_SLEW_EN: commands write target registers and each
// output walks toward its target by at most 8 counts every 2^16 clk cycles.
module motor_cmd_ctrl #(
    parameter int NUM_MOTORS     = 4,
    parameter int PERIOD_W       = 11,
    parameter int PERIOD_MAX     = 2000,
    parameter int WORD_W         = 32,
    parameter int TIMEOUT_CYCLES = 5000000
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [WORD_W-1:0]              spi_word,
    input  logic                           spi_ready,
    output logic [NUM_MOTORS*PERIOD_W-1:0] period_out,
    output logic [WORD_W-1:0]              reply_word,
    output logic                           busy,
    output logic                           failsafe
);

    localparam int IDX_W = (NUM_MOTORS > 1) ? $clog2(NUM_MOTORS) : 1;
    localparam int WD_W  = $clog2(TIMEOUT_CYCLES) + 1;

    localparam logic [PERIOD_W-1:0] PMAX     = PERIOD_W'(PERIOD_MAX);
    localparam logic [PERIOD_W:0]   PMAX_X   = (PERIOD_W + 1)'(PERIOD_MAX);
    localparam logic [WD_W-1:0]     WD_LAST  = WD_W'(TIMEOUT_CYCLES - 1);
    localparam logic [IDX_W-1:0]    IDX_LAST = IDX_W'(NUM_MOTORS - 1);

    localparam logic [1:0] OP_SET = 2'd0;
    localparam logic [1:0] OP_INC = 2'd1;
    localparam logic [1:0] OP_DEC = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE,
        S_DECODE,
        S_APPLY,
        S_REPLY
    } state_t;

    state_t              state_q;
    logic                sync1_q, sync2_q, rdy_prev_q;
    logic [WORD_W-1:0]   word_s1_q, word_s2_q;
    logic [WORD_W-1:0]   cmd_q, pend_q;
    logic                pend_full_q, ovr_pend_q;
    logic [IDX_W-1:0]    idx_q;
    logic [PERIOD_W-1:0] per_q [NUM_MOTORS];
    logic                overrun_q, fs_seen_q, clamp_q, bad_q;
    logic [WD_W-1:0]     wd_q;
    logic                failsafe_q, busy_q;
    logic [WORD_W-1:0]   reply_q;

    logic                  rise_d;
    logic [NUM_MOTORS-1:0] mask_d;
    logic [1:0]            op_d;
    logic [PERIOD_W-1:0]   val_d, cur_d, new_d, low_d;
    logic [PERIOD_W:0]     sum_d;
    logic                  sat_d;
    logic                  wd_hit_d;
    logic [31:0]           reply_d;
    logic [PERIOD_W-1:0]   drv_d [NUM_MOTORS];

    // Reserved and out-of-range mask bits are intentionally ignored.
    logic unused_cmd_bits;
    assign unused_cmd_bits = ^cmd_q;

    always_comb begin
        rise_d = sync2_q & ~rdy_prev_q;
        mask_d = cmd_q[24 +: NUM_MOTORS];
        op_d   = cmd_q[13:12];
        val_d  = PERIOD_W'(cmd_q[23:14]);
        cur_d  = per_q[idx_q];
        // One extra bit so INC overflow past PERIOD_MAX is visible before clamping.
        sum_d  = {1'b0, cur_d} + {1'b0, val_d};
        new_d  = cur_d;
        sat_d  = 1'b0;
        case (op_d)
            OP_SET: begin
                if (val_d > PMAX) begin
                    new_d = PMAX;
                    sat_d = 1'b1;
                end else begin
                    new_d = val_d;
                end
            end
            OP_INC: begin
                if (sum_d > PMAX_X) begin
                    new_d = PMAX;
                    sat_d = 1'b1;
                end else begin
                    new_d = sum_d[PERIOD_W-1:0];
                end
            end
            OP_DEC: begin
                if (cur_d > val_d) begin
                    new_d = cur_d - val_d;
                end else begin
                    new_d = '0;
                    sat_d = (cur_d < val_d);
                end
            end
            default: ;
        endcase
        // Lowest selected motor wins: scan from the top so index 0 is written last.
        low_d = '0;
        for (int i = NUM_MOTORS - 1; i >= 0; i--) begin
            if (mask_d[i]) low_d = per_q[i];
        end
        wd_hit_d = (wd_q == WD_LAST);
        reply_d  = {cmd_q[7:0], overrun_q, fs_seen_q, clamp_q, bad_q,
                    2'b00, op_d, 16'(low_d)};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            sync1_q     <= 1'b0;
            sync2_q     <= 1'b0;
            rdy_prev_q  <= 1'b0;
            word_s1_q   <= '0;
            word_s2_q   <= '0;
            cmd_q       <= '0;
            pend_q      <= '0;
            pend_full_q <= 1'b0;
            ovr_pend_q  <= 1'b0;
            idx_q       <= '0;
            overrun_q   <= 1'b0;
            fs_seen_q   <= 1'b0;
            clamp_q     <= 1'b0;
            bad_q       <= 1'b0;
            wd_q        <= '0;
            failsafe_q  <= 1'b0;
            busy_q      <= 1'b0;
            reply_q     <= '0;
            for (int i = 0; i < NUM_MOTORS; i++) per_q[i] <= '0;
        end else begin
            // The word is delayed alongside the ready synchronizer so the captured
            // value is the one present while spi_ready was first sampled high.
            sync1_q    <= spi_ready;
            sync2_q    <= sync1_q;
            rdy_prev_q <= sync2_q;
            word_s1_q  <= spi_word;
            word_s2_q  <= word_s1_q;

            if (state_q == S_DECODE && mask_d != '0) begin
                wd_q <= '0;
            end else if (!wd_hit_d) begin
                wd_q <= wd_q + 1'b1;
            end

            // failsafe_seen reports that failsafe was in force at any point
            // since the previous reply, not only the instant it tripped.
            fs_seen_q <= wd_hit_d | failsafe_q | (fs_seen_q & (state_q != S_REPLY));

            case (state_q)
                S_IDLE: begin
                    if (rise_d) begin
                        cmd_q   <= word_s2_q;
                        busy_q  <= 1'b1;
                        state_q <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    if (mask_d == '0) begin
                        bad_q   <= 1'b1;
                        state_q <= S_REPLY;
                    end else begin
                        idx_q   <= '0;
                        state_q <= S_APPLY;
                    end
                end
                S_APPLY: begin
                    if (mask_d[idx_q]) begin
                        per_q[idx_q] <= new_d;
                        if (sat_d) clamp_q <= 1'b1;
                    end
                    if (op_d == OP_SET) failsafe_q <= 1'b0;
                    if (idx_q == IDX_LAST) begin
                        state_q <= S_REPLY;
                    end else begin
                        idx_q <= idx_q + 1'b1;
                    end
                end
                S_REPLY: begin
                    reply_q <= WORD_W'(reply_d);
                    clamp_q <= 1'b0;
                    bad_q   <= 1'b0;
                    if (pend_full_q) begin
                        // An overrun belongs to the reply of the word that was
                        // waiting when the newer word got lost.
                        cmd_q     <= pend_q;
                        overrun_q <= ovr_pend_q;
                        state_q   <= S_DECODE;
                        if (rise_d) begin
                            pend_q <= word_s2_q;
                        end else begin
                            pend_full_q <= 1'b0;
                        end
                        ovr_pend_q <= 1'b0;
                    end else if (rise_d) begin
                        cmd_q     <= word_s2_q;
                        overrun_q <= 1'b0;
                        state_q   <= S_DECODE;
                    end else begin
                        overrun_q <= 1'b0;
                        busy_q    <= 1'b0;
                        state_q   <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase

            if (rise_d && (state_q == S_DECODE || state_q == S_APPLY)) begin
                if (pend_full_q) begin
                    ovr_pend_q <= 1'b1;
                end else begin
                    pend_q      <= word_s2_q;
                    pend_full_q <= 1'b1;
                end
            end

            // Timeout overrides any write made by APPLY in the same cycle.
            if (wd_hit_d) begin
                failsafe_q <= 1'b1;
                for (int i = 0; i < NUM_MOTORS; i++) per_q[i] <= '0;
            end
        end
    end

`ifdef MOTOR_CTRL_SLEW_EN
    localparam logic [PERIOD_W-1:0] STEP = PERIOD_W'(8);

    logic [15:0]         slew_pre_q;
    logic [PERIOD_W-1:0] out_q [NUM_MOTORS];

    // per_q holds the targets here; out_q chases them.
    always_ff @(posedge clk) begin
        if (reset) begin
            slew_pre_q <= '0;
            for (int i = 0; i < NUM_MOTORS; i++) out_q[i] <= '0;
        end else begin
            slew_pre_q <= slew_pre_q + 16'd1;
            for (int i = 0; i < NUM_MOTORS; i++) begin
                if (wd_hit_d) begin
                    out_q[i] <= '0;
                end else if (slew_pre_q == 16'hFFFF) begin
                    if (per_q[i] > out_q[i]) begin
                        out_q[i] <= (per_q[i] - out_q[i] > STEP) ? out_q[i] + STEP : per_q[i];
                    end else if (per_q[i] < out_q[i]) begin
                        out_q[i] <= (out_q[i] - per_q[i] > STEP) ? out_q[i] - STEP : per_q[i];
                    end
                end
            end
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_MOTORS; i++) drv_d[i] = out_q[i];
    end
`else
    always_comb begin
        for (int i = 0; i < NUM_MOTORS; i++) drv_d[i] = per_q[i];
    end
`endif

    // Commands keep updating the registers during failsafe; only the outputs are held at 0.
    always_comb begin
        period_out = '0;
        for (int i = 0; i < NUM_MOTORS; i++) begin
            period_out[i*PERIOD_W +: PERIOD_W] = failsafe_q ? '0 : drv_d[i];
        end
    end

    assign reply_word = reply_q;
    assign busy       = busy_q;
    assign failsafe   = failsafe_q;

endmodule

// File: tb/tb_motor_cmd_ctrl.sv
// Self-checking bench for motor_cmd_ctrl: directed table, random commands against a
// transaction-level model, pending/overrun burst, watchdog failsafe, reset mid-command.
module tb_motor_cmd_ctrl;
    localparam int N  = 4;
    localparam int PW = 11;
    localparam int TO = 1000;
    localparam int PMAXV = 2000;

    logic              clk = 1'b0;
    logic              reset;
    logic [31:0]       spi_word;
    logic              spi_ready;
    logic [N*PW-1:0]   period_out;
    logic [31:0]       reply_word;
    logic              busy;
    logic              failsafe;

    always #5 clk = ~clk;

    motor_cmd_ctrl #(
        .NUM_MOTORS    (N),
        .PERIOD_W      (PW),
        .PERIOD_MAX    (PMAXV),
        .WORD_W        (32),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .spi_word  (spi_word),
        .spi_ready (spi_ready),
        .period_out(period_out),
        .reply_word(reply_word),
        .busy      (busy),
        .failsafe  (failsafe)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] mk(input logic [7:0] m, input int v,
                                       input logic [1:0] op, input logic [7:0] tag);
        logic [9:0] vv;
        vv = 10'(v);
        return {m, vv, op, 4'h0, tag};
    endfunction

    function automatic logic [N*PW-1:0] pk(input int a, input int b, input int c, input int d);
        return {11'(d), 11'(c), 11'(b), 11'(a)};
    endfunction

    // Raise spi_ready with a word, measure ready-to-busy latency and busy length.
    task automatic send(input logic [31:0] w, output int lat, output int blen);
        @(posedge clk); #1;
        spi_word  = w;
        spi_ready = 1'b1;
        lat  = 0;
        blen = 0;
        while (!busy && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        spi_ready = 1'b0;
        if (busy) begin
            blen = 1;
            while (busy && blen < 100) begin
                @(posedge clk); #1;
                if (busy) blen++;
            end
        end
        repeat (3) @(posedge clk);
    endtask

    typedef struct {
        logic [31:0]     word;
        logic [31:0]     reply;
        logic [N*PW-1:0] per;
        int              blen;
    } vec_t;

    vec_t tbl [12];
    int   mp  [N];

    initial begin
        int lat, blen, n;
        logic [31:0] last;
        logic [31:0] rq [$];

        // Directed table, each row starting from the state the previous row left.
        tbl[0]  = '{mk(8'h01, 250, 2'd0, 8'h05), 32'h0500_00FA, pk(250, 0, 0, 0), 6};
        tbl[1]  = '{mk(8'h01, 1000, 2'd0, 8'h11), 32'h1100_03E8, pk(1000, 0, 0, 0), 6};
        tbl[2]  = '{mk(8'h01, 900, 2'd1, 8'h12), 32'h1201_076C, pk(1900, 0, 0, 0), 6};
        tbl[3]  = '{mk(8'h01, 200, 2'd1, 8'h13), 32'h1321_07D0, pk(2000, 0, 0, 0), 6};
        tbl[4]  = '{mk(8'h06, 100, 2'd0, 8'h14), 32'h1400_0064, pk(2000, 100, 100, 0), 6};
        tbl[5]  = '{mk(8'h04, 400, 2'd1, 8'h15), 32'h1501_01F4, pk(2000, 100, 500, 0), 6};
        tbl[6]  = '{mk(8'h06, 300, 2'd2, 8'h16), 32'h1622_0000, pk(2000, 0, 200, 0), 6};
        tbl[7]  = '{mk(8'h00, 5, 2'd0, 8'h17), 32'h1710_0000, pk(2000, 0, 200, 0), 2};
        tbl[8]  = '{mk(8'hF0, 5, 2'd0, 8'h18), 32'h1810_0000, pk(2000, 0, 200, 0), 2};
        tbl[9]  = '{mk(8'h0F, 77, 2'd3, 8'h19), 32'h1903_07D0, pk(2000, 0, 200, 0), 6};
        tbl[10] = '{mk(8'h09, 1023, 2'd2, 8'h1A), 32'h1A22_03D1, pk(977, 0, 200, 0), 6};
        tbl[11] = '{mk(8'hFF, 5, 2'd0, 8'h1B), 32'h1B00_0005, pk(5, 5, 5, 5), 6};

        reset     = 1'b1;
        spi_ready = 1'b0;
        spi_word  = '0;
        repeat (3) @(posedge clk); #1;
        check("reset period_out", period_out, '0);
        check("reset reply_word", reply_word, '0);
        check("reset busy", busy, 0);
        check("reset failsafe", failsafe, 0);
        reset = 1'b0;

        for (int r = 0; r < 12; r++) begin
            send(tbl[r].word, lat, blen);
            if (r == 0) check("ready-to-busy latency", lat, 3);
            check($sformatf("row%0d busy cycles", r), blen, tbl[r].blen);
            check($sformatf("row%0d reply", r), reply_word, tbl[r].reply);
            check($sformatf("row%0d periods", r), period_out, tbl[r].per);
        end

        // Random commands against a transaction-level model.
        for (int i = 0; i < N; i++) mp[i] = 5;
        for (int k = 0; k < 40; k++) begin
            logic [7:0] m;
            int v, op, low, np;
            logic cl, bad, first;
            m  = 8'($urandom_range(0, 255));
            v  = $urandom_range(0, 1023);
            op = $urandom_range(0, 3);
            cl = 1'b0;
            bad = (m[N-1:0] == '0);
            low = 0;
            first = 1'b1;
            for (int i = 0; i < N; i++) begin
                if (m[i]) begin
                    np = mp[i];
                    if (op == 0) begin
                        np = (v > PMAXV) ? PMAXV : v;
                        if (v > PMAXV) cl = 1'b1;
                    end else if (op == 1) begin
                        np = mp[i] + v;
                        if (np > PMAXV) begin np = PMAXV; cl = 1'b1; end
                    end else if (op == 2) begin
                        np = (mp[i] > v) ? mp[i] - v : 0;
                        if (mp[i] < v) cl = 1'b1;
                    end
                    mp[i] = np;
                    if (first) begin low = np; first = 1'b0; end
                end
            end
            send(mk(m, v, 2'(op), 8'(k)), lat, blen);
            check($sformatf("rand%0d busy cycles", k), blen, bad ? 2 : N + 2);
            check($sformatf("rand%0d reply", k), reply_word,
                  {8'(k), 2'b00, cl, bad, 2'b00, 2'(op), 16'(low)});
            check($sformatf("rand%0d periods", k), period_out, pk(mp[0], mp[1], mp[2], mp[3]));
        end

        // Three pulses two cycles apart: second word waits in the pending slot,
        // the third arrives while the slot is full and is lost.
        last = reply_word;
        for (int c = 0; c < 46; c++) begin
            @(posedge clk); #1;
            if (reply_word != last) begin
                rq.push_back(reply_word);
                last = reply_word;
            end
            case (c)
                0: begin spi_word = mk(8'h01, 111, 2'd0, 8'hA1); spi_ready = 1'b1; end
                2: begin spi_word = mk(8'h01, 222, 2'd0, 8'hB2); spi_ready = 1'b1; end
                4: begin spi_word = mk(8'h01, 333, 2'd0, 8'hC3); spi_ready = 1'b1; end
                default: spi_ready = 1'b0;
            endcase
        end
        mp[0] = 222;
        check("burst reply count", rq.size(), 2);
        check("burst first reply", (rq.size() > 0) ? rq[0] : 32'h0, 32'hA100_006F);
        check("burst second reply overrun", (rq.size() > 1) ? rq[1] : 32'h0, 32'hB280_00DE);
        check("burst periods", period_out, pk(mp[0], mp[1], mp[2], mp[3]));
        check("burst busy idle", busy, 0);

        // Watchdog: count is cleared during the SET's DECODE cycle and trips
        // TO edges after that, i.e. TO+1 samples after busy is first seen.
        @(posedge clk); #1;
        spi_word  = mk(8'h0F, 500, 2'd0, 8'h50);
        spi_ready = 1'b1;
        n = 0;
        while (!busy && n < 20) begin @(posedge clk); #1; n++; end
        spi_ready = 1'b0;
        n = 0;
        while (!failsafe && n < TO + 200) begin @(posedge clk); #1; n++; end
        check("failsafe trip cycle", n, TO + 1);
        check("failsafe asserted", failsafe, 1);
        check("failsafe periods zero", period_out, '0);

        send(mk(8'h0F, 10, 2'd1, 8'h51), lat, blen);
        check("failsafe INC periods", period_out, '0);
        check("failsafe INC reply", reply_word, 32'h5141_000A);
        check("failsafe held after INC", failsafe, 1);

        send(mk(8'h01, 300, 2'd0, 8'h52), lat, blen);
        check("SET clears failsafe", failsafe, 0);
        check("SET after failsafe periods", period_out, pk(300, 10, 10, 10));
        check("SET after failsafe reply", reply_word, 32'h5240_012C);

        // Reset in the middle of APPLY abandons the command.
        @(posedge clk); #1;
        spi_word  = mk(8'h0F, 700, 2'd0, 8'h60);
        spi_ready = 1'b1;
        n = 0;
        while (!busy && n < 20) begin @(posedge clk); #1; n++; end
        spi_ready = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        check("mid-apply periods", period_out, pk(700, 10, 10, 10));
        reset = 1'b1;
        @(posedge clk); #1;
        check("mid reset periods", period_out, '0);
        check("mid reset reply", reply_word, '0);
        check("mid reset busy", busy, 0);
        check("mid reset failsafe", failsafe, 0);
        reset = 1'b0;
        repeat (6) begin @(posedge clk); #1; end
        check("no resume after reset", busy, 0);
        check("periods stay zero after reset", period_out, '0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
